// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between the fetch (IF) and data (MEM) stages, with read-tag return routing.
// Optional macro FETCH_FAIR_EN bounds consecutive data grants so a waiting fetch cannot starve.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    input  logic              flush,
    input  logic              halt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 4 || MAX_STREAK < 1) begin : g_param_check
        $error("mem_port_arbiter: RD_LAT must be 1..4 and MAX_STREAK at least 1");
    end

    logic              grant_d;
    logic              grant_f;
    logic              fair_c;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_own_q;
    logic [RD_LAT-1:0] tag_vld_d;
    logic [RD_LAT-1:0] tag_own_d;
    logic              exit_vld;
    logic              exit_own;

`ifdef FETCH_FAIR_EN
    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_q;

    // Hand the port to fetch once data has won MAX_STREAK times in a row against it.
    assign fair_c = (streak_q == STREAK_W'(MAX_STREAK)) && if_req && !halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (grant_f || !if_req) begin
            streak_q <= '0;
        end else if (grant_d && !halt) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end
`else
    assign fair_c = 1'b0;
`endif

    assign grant_d   = mem_req && !fair_c;
    assign grant_f   = if_req && !halt && !grant_d;
    assign if_stall  = if_req && !grant_f;
    assign mem_stall = mem_req && !grant_d;

    assign ram_en    = grant_d || grant_f;
    assign ram_we    = grant_d && mem_we;
    assign ram_addr  = grant_d ? mem_addr : (grant_f ? if_addr : '0);
    assign ram_wdata = grant_d ? mem_wdata : '0;

    // Tag shift pipeline: stage 0 takes this cycle's read grant; flush kills every fetch-owned tag.
    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = grant_f || (grant_d && !mem_we);
        tag_own_d[0] = grant_d;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
        if (flush) begin
            tag_vld_d = tag_vld_d & tag_own_d;
        end
    end

    // A fetch tag leaving the pipe during a flush cycle is dropped as well.
    assign exit_own = tag_own_q[RD_LAT-1];
    assign exit_vld = tag_vld_q[RD_LAT-1] && !(flush && !exit_own);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
            busy      <= 1'b0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
            busy      <= |tag_vld_d;
            if_valid  <= exit_vld && !exit_own;
            mem_valid <= exit_vld && exit_own;
            if (exit_vld && !exit_own) begin
                if_rdata <= ram_rdata;
            end
            if (exit_vld && exit_own) begin
                mem_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model (reference memory + pending-read queue).
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned MAX_STREAK = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req, mem_req, mem_we, flush, halt;
    logic [ADDR_W-1:0] if_addr, mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_stall, if_valid, mem_stall, mem_valid;
    logic [DATA_W-1:0] if_rdata, mem_rdata;
    logic              ram_en, ram_we, busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .flush(flush), .halt(halt),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        case (i)
            0:       return 16'h1111;
            1:       return 16'h2222;
            2:       return 16'h3333;
            16:      return 16'hBEEF;
            default: return 16'(i * 16'h03C1 + 7);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural single-port RAM with RD_LAT-cycle read latency.
    logic [DATA_W-1:0] ram [256];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    assign ram_rdata = rpipe[RD_LAT-1];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        for (int i = 0; i < int'(RD_LAT); i++) rpipe[i] <= '0;
        forever begin
            @(posedge clk);
            if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
            rpipe[0] <= ram[ram_addr];
            for (int i = 1; i < int'(RD_LAT); i++) rpipe[i] <= rpipe[i-1];
        end
    end

    // Transaction-level reference: each read is a record with its owner, data and due cycle.
    typedef struct {
        bit                live;
        bit                own;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    rd_t               pend[$];
    logic [DATA_W-1:0] ref_mem [256];
    int                cyc = 0;
    int                streak = 0;
    bit                e_ifv = 0, e_memv = 0;
    logic [DATA_W-1:0] e_ifd = '0, e_memd = '0;

    initial begin
        bit fair, dg, fg, e_busy;
        logic [ADDR_W-1:0] e_addr;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                e_ifv = 0; e_memv = 0; e_ifd = '0; e_memd = '0; streak = 0;
                chk("rst_if_valid", 32'(if_valid), 0);
                chk("rst_mem_valid", 32'(mem_valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_if_rdata", 32'(if_rdata), 0);
                chk("rst_mem_rdata", 32'(mem_rdata), 0);
            end else begin
                fair = 0;
`ifdef FETCH_FAIR_EN
                fair = (streak == int'(MAX_STREAK)) && if_req && !halt;
`endif
                dg = mem_req && !fair;
                fg = if_req && !halt && !dg;
                e_addr = dg ? mem_addr : (fg ? if_addr : 8'h00);
                e_busy = 0;
                foreach (pend[i]) if (pend[i].live) e_busy = 1;

                chk("if_stall", 32'(if_stall), 32'(if_req && !fg));
                chk("mem_stall", 32'(mem_stall), 32'(mem_req && !dg));
                chk("ram_en", 32'(ram_en), 32'(dg || fg));
                chk("ram_we", 32'(ram_we), 32'(dg && mem_we));
                chk("ram_addr", 32'(ram_addr), 32'(e_addr));
                chk("ram_wdata", 32'(ram_wdata), dg ? 32'(mem_wdata) : 32'd0);
                chk("if_valid", 32'(if_valid), 32'(e_ifv));
                chk("if_rdata", 32'(if_rdata), 32'(e_ifd));
                chk("mem_valid", 32'(mem_valid), 32'(e_memv));
                chk("mem_rdata", 32'(mem_rdata), 32'(e_memd));
                chk("busy", 32'(busy), 32'(e_busy));

                if (flush) foreach (pend[i]) if (!pend[i].own) pend[i].live = 0;
                if (dg && mem_we) ref_mem[mem_addr] = mem_wdata;
                else if (dg) pend.push_back('{live: 1'b1, own: 1'b1, data: ref_mem[mem_addr],
                                              due: cyc + int'(RD_LAT) + 1});
                if (fg) pend.push_back('{live: !flush, own: 1'b0, data: ref_mem[if_addr],
                                         due: cyc + int'(RD_LAT) + 1});
                if (fg || !if_req) streak = 0;
                else if (dg && !halt) streak++;

                e_ifv = 0; e_memv = 0;
                while (pend.size() > 0 && pend[0].due == cyc + 1) begin
                    if (pend[0].live) begin
                        if (pend[0].own) begin e_memv = 1; e_memd = pend[0].data; end
                        else begin e_ifv = 1; e_ifd = pend[0].data; end
                    end
                    void'(pend.pop_front());
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; mem_req = 0; mem_we = 0; flush = 0; halt = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] exp_pat;
        rst_n = 0;
        idle_inputs();
        repeat (3) tick();
        rst_n = 1;
        tick();

        // Fetch stream 0,1,2: responses RD_LAT+1 cycles after each grant.
        if_req = 1; if_addr = 8'h00;
        @(negedge clk); chk("t1_if_stall", 32'(if_stall), 0);
        tick(); if_addr = 8'h01;
        tick(); if_addr = 8'h02;
        tick(); if_req = 0;
        @(negedge clk); chk("t1_v0", {15'd0, if_valid, if_rdata}, {16'd1, 16'h1111});
        tick();
        @(negedge clk); chk("t1_v1", {15'd0, if_valid, if_rdata}, {16'd1, 16'h2222});
        tick();
        @(negedge clk); chk("t1_v2", {15'd0, if_valid, if_rdata}, {16'd1, 16'h3333});
        repeat (3) tick();

        // Conflict: data wins, fetch follows.
        if_req = 1; if_addr = 8'h30; mem_req = 1; mem_we = 0; mem_addr = 8'h10;
        @(negedge clk);
        chk("t2_mem_stall", 32'(mem_stall), 0);
        chk("t2_if_stall", 32'(if_stall), 1);
        chk("t2_ram_addr", 32'(ram_addr), 32'h10);
        tick(); mem_req = 0;
        @(negedge clk);
        chk("t2_f_stall", 32'(if_stall), 0);
        chk("t2_f_addr", 32'(ram_addr), 32'h30);
        tick(); if_req = 0;
        tick();
        @(negedge clk); chk("t2_ldr", {15'd0, mem_valid, mem_rdata}, {16'd1, 16'hBEEF});
        repeat (3) tick();

        // STR then LDR to the same address.
        mem_req = 1; mem_we = 1; mem_addr = 8'h20; mem_wdata = 16'hA5A5;
        @(negedge clk); chk("t3_we_str", 32'(ram_we), 1);
        tick(); mem_we = 0; mem_wdata = '0;
        @(negedge clk); chk("t3_we_ldr", 32'(ram_we), 0);
        tick(); mem_req = 0;
        tick();
        @(negedge clk); chk("t3_no_str_resp", 32'(mem_valid), 0);
        tick();
        @(negedge clk); chk("t3_raw", {15'd0, mem_valid, mem_rdata}, {16'd1, 16'hA5A5});
        repeat (3) tick();

        // Flush the cycle after a fetch grant; a concurrent data read survives.
        if_req = 1; if_addr = 8'h05;
        tick(); if_req = 0; flush = 1; mem_req = 1; mem_we = 0; mem_addr = 8'h10;
        tick(); flush = 0; mem_req = 0;
        tick();
        @(negedge clk); chk("t4_flushed", 32'(if_valid), 0);
        tick();
        @(negedge clk); chk("t4_data_ok", {15'd0, mem_valid, mem_rdata}, {16'd1, 16'hBEEF});
        repeat (3) tick();

        // Halt blocks fetch only; then reset with reads in flight.
        halt = 1; if_req = 1; if_addr = 8'h07;
        @(negedge clk);
        chk("t5_halt_stall", 32'(if_stall), 1);
        chk("t5_halt_en", 32'(ram_en), 0);
        tick(); mem_req = 1; mem_addr = 8'h10;
        @(negedge clk);
        chk("t5_ldr_en", 32'(ram_en), 1);
        chk("t5_ldr_stall", 32'(mem_stall), 0);
        tick(); halt = 0; mem_req = 0; if_addr = 8'h03;
        @(negedge clk); chk("t5_busy", 32'(busy), 1);
        tick(); mem_req = 1; if_req = 0;
        #2 rst_n = 0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_valid", {30'd0, if_valid, mem_valid}, 0);
        tick(); idle_inputs(); rst_n = 1;
        repeat (5) tick();
        @(negedge clk); chk("t5_no_late", {30'd0, if_valid, mem_valid, busy}, 0);
        tick();

        // Sustained contention: grant pattern over ten cycles.
        if_req = 1; if_addr = 8'h41; mem_req = 1; mem_we = 0; mem_addr = 8'h40;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[i] = ram_en && (ram_addr == 8'h40);
            tick();
        end
`ifdef FETCH_FAIR_EN
        exp_pat = 10'b0111101111;
`else
        exp_pat = 10'b1111111111;
`endif
        chk("t6_grant_pattern", 32'(pat), 32'(exp_pat));
        idle_inputs();
        repeat (4) tick();

        // Randomized traffic, including one asynchronous reset mid-stream.
        for (int n = 0; n < 3000; n++) begin
            if_req    = ($urandom_range(0, 3) != 0);
            if_addr   = 8'($urandom_range(0, 15));
            mem_req   = ($urandom_range(0, 2) == 0);
            mem_we    = ($urandom_range(0, 1) == 1);
            mem_addr  = 8'($urandom_range(0, 15));
            mem_wdata = 16'($urandom);
            flush     = ($urandom_range(0, 11) == 0);
            halt      = ($urandom_range(0, 9) == 0);
            if (n == 1500) begin
                #2 rst_n = 0;
                tick();
                rst_n = 1;
            end else begin
                tick();
            end
        end
        idle_inputs();
        repeat (8) tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data RAM between the pipeline's fetch stage (IF) and memory stage (MEM: LDR/STR).
- Grants at most one access per cycle and drives stall back to the losing stage.
- Tracks in-flight reads through a tag pipeline so each read response returns to its issuer; supports branch flush and HALT.
- Sits between the pipeline registers and the RAM macro; its stall outputs feed the hazard unit's stall/pc_load logic.

Parameters:
- ADDR_W, 8, RAM word-address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles from ram_en (legal 1..4).
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits (used only with FETCH_FAIR_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch requests a read this cycle.
- if_addr  in  ADDR_W  fetch address (PC).
- if_stall  out  1  combinational; if_req not granted this cycle.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  if_rdata valid this cycle.
- mem_req  in  1  MEM stage requests an access.
- mem_we  in  1  1 = STR write, 0 = LDR read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_stall  out  1  combinational; mem_req not granted.
- mem_rdata  out  DATA_W  load data.
- mem_valid  out  1  mem_rdata valid this cycle.
- flush  in  1  branch taken: discard in-flight fetch responses.
- halt  in  1  HALT decoded: block new fetch grants.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, RD_LAT cycles after ram_en with ram_we = 0.
- busy  out  1  any read in flight.

Behaviour:
- Reset (rst_n low, async):
  - Tag pipeline cleared.
  - if_valid, mem_valid, busy = 0; if_rdata, mem_rdata = 0.
  - Streak counter = 0.
  - Reads in flight at reset are dropped; no response after release.
- Arbitration (combinational, every cycle):
  - Data wins over fetch.
  - mem_req = 1 → data granted.
  - Else if_req = 1 and halt = 0 → fetch granted.
  - Else no access.
  - if_stall = if_req and not fetch granted (includes halt).
  - mem_stall = mem_req and not data granted.
- RAM drive:
  - ram_en = any grant.
  - ram_addr / ram_wdata / ram_we taken from the granted requester.
  - ram_we = 1 only for a data grant with mem_we = 1.
  - Idle cycle: ram_addr and ram_wdata = 0.
- Writes: complete in the grant cycle; produce no response and no tag.
- Read tags:
  - Each read grant pushes a tag {valid, owner} into an RD_LAT-deep shift pipeline (owner: 0 = fetch, 1 = data).
  - At pipeline exit, ram_rdata is registered into the owner's rdata, and the owner's valid is pulsed for one cycle.
  - Total response latency = RD_LAT + 1 cycles after the grant.
  - rdata holds its last value when valid = 0.
- Flush: in the flush cycle, all in-flight tags with owner = fetch are invalidated, including a fetch granted in that same cycle. Data tags are unaffected.
- Halt: only blocks fetch grants; data accesses still proceed. In-flight fetch responses still return.
- busy = OR of tag valid bits.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write completes before the later read).
- Throughput: one access per cycle; back-to-back reads from alternating owners are legal.

Optional Feature:
- Macro FETCH_FAIR_EN.
- When defined:
  - A streak counter (width clog2(MAX_STREAK+1)) increments each cycle that data is granted while if_req = 1 and halt = 0.
  - It resets to 0 on any fetch grant or when if_req = 0.
  - When the counter equals MAX_STREAK and both stages request, fetch is granted instead, mem_stall = 1, and the counter clears.
- When undefined: no counter; strict data priority; fetch may starve indefinitely.

Test Plan:
1. Fetch only, RD_LAT = 1: if_req with addresses 0x00, 0x01, 0x02 in consecutive cycles, RAM preloaded with 0x1111, 0x2222, 0x3333 → if_valid pulses in cycles 2, 3, 4 carrying 0x1111, 0x2222, 0x3333; if_stall = 0 throughout.
2. Conflict: if_req and mem_req (LDR at 0x10 = 0xBEEF) in the same cycle → mem_stall = 0, if_stall = 1, ram_addr = 0x10; mem_valid with 0xBEEF two cycles later; fetch granted the following cycle.
3. STR then LDR: STR 0xA5A5 to 0x20, then LDR 0x20 next cycle → ram_we = 1 for one cycle only; mem_rdata = 0xA5A5; no mem_valid for the STR.
4. Flush, RD_LAT = 2: fetch 0x05, then assert flush the cycle after the grant → no if_valid for 0x05; a data read issued concurrently still returns.
5. halt = 1 with if_req = 1 → if_stall = 1, ram_en = 0; an LDR during halt is granted normally. rst_n low with reads in flight → all valid outputs = 0, busy = 0, no late responses after release.
6. FETCH_FAIR_EN, MAX_STREAK = 4: hold mem_req and if_req for 10 cycles → grant pattern D, D, D, D, F, D, D, D, D, F; without the macro → ten consecutive D grants.
